// File: rtl/ysyx_22040237_fetch_seq_ctrl_if.sv
// Instruction-memory fetch channel between the sequencer (master) and the memory (slave).
// Request is level-held until the response; no backpressure on the response side.
interface ysyx_22040237_fetch_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ysyx_22040237_fetch_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches from variable-latency memory,
// opens a one-cycle execute window per instruction and halts on ebreak or fetch timeout.
module ysyx_22040237_fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  ysyx_22040237_fetch_seq_ctrl_if.master       imem,
  output logic [31:0]                          inst,
  output logic                                 exec_en,
  output logic [31:0]                          pc,
  input  logic [31:0]                          next_pc,
  input  logic                                 inst_ebreak,
  output logic                                 rf_wr_gate,
  output logic                                 halted,
  output logic                                 fetch_err,
  output logic [63:0]                          retire_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  // Last wait count at which a missing response is still tolerated.
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      fetch_err  <= 1'b0;
      retire_cnt <= 64'd0;
      wait_cnt   <= 8'd0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            retire_cnt <= 64'd0;
            fetch_err  <= 1'b0;
            wait_cnt   <= 8'd0;
          end
        end
        FETCH: begin
          // A response in the same cycle the budget runs out still wins.
          if (imem.imem_rvalid) begin
            inst     <= imem.imem_rdata;
            wait_cnt <= 8'd0;
            state    <= EXEC;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        EXEC: begin
          retire_cnt <= retire_cnt + 64'd1;
          if (inst_ebreak) begin
            state <= HALT;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs are pure state decodes so no input reaches them combinationally.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign exec_en        = (state == EXEC);
  assign rf_wr_gate     = (state == EXEC);
  assign halted         = (state == HALT);

endmodule

// File: doc/ysyx_22040237_fetch_seq_ctrl.md
Name: ysyx_22040237_fetch_seq_ctrl

Overview:
- Multi-cycle sequencer that drives the single-cycle CPU datapath against an instruction memory with variable latency.
- Owns the architectural PC and issues fetch requests. Latches the returned instruction and opens a one-cycle execute window that gates register-file writeback and PC update.
- Halts on ebreak or on a fetch timeout.
- Sits between the memory interface and the PC/IFU/IDU/EXU/regfile datapath, replacing the free-running PC register.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset and on start.
- TIMEOUT, 255, maximum wait cycles for imem_rvalid before a fetch error; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that starts execution from RESET_PC; ignored unless in IDLE or HALT.
- imem_req  output  1  fetch request; held high until the response.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_rvalid  input  1  response valid; sampled only in FETCH.
- imem_rdata  input  32  instruction word; valid with imem_rvalid.
- inst  output  32  latched instruction presented to the IFU/IDU.
- exec_en  output  1  high for exactly one cycle per instruction (EXEC state).
- pc  output  32  architectural PC of the instruction in flight.
- next_pc  input  32  datapath-computed successor PC; sampled in EXEC.
- inst_ebreak  input  1  ebreak decode from IDU; sampled in EXEC.
- rf_wr_gate  output  1  qualifies regfile write enable; equals exec_en.
- halted  output  1  high in HALT.
- fetch_err  output  1  sticky; set on timeout, cleared by reset or start.
- retire_cnt  output  64  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Reset state is IDLE.
- Reset values: pc=RESET_PC, inst=32'h0000_0013 (nop), imem_req=0, exec_en=0, rf_wr_gate=0, halted=0, fetch_err=0, retire_cnt=0, wait counter=0.
- IDLE:
  - start -> FETCH; pc<=RESET_PC; retire_cnt<=0; fetch_err<=0.
- FETCH:
  - imem_req=1; imem_addr=pc.
  - Wait counter increments each cycle imem_rvalid=0.
  - On imem_rvalid=1: inst<=imem_rdata; counter<=0; -> EXEC. Minimum fetch latency is 1 cycle, because a response in the first FETCH cycle is accepted.
  - If the counter reaches TIMEOUT with imem_rvalid still 0: fetch_err<=1; -> HALT; imem_req drops the next cycle.
  - rvalid in the same cycle the counter hits TIMEOUT counts as success.
- EXEC (exactly 1 cycle):
  - exec_en=1; rf_wr_gate=1; imem_req=0.
  - If inst_ebreak=1: -> HALT; pc unchanged; retire_cnt increments (ebreak retires).
  - Else: pc<=next_pc; retire_cnt<=retire_cnt+1; -> FETCH.
  - next_pc is taken verbatim; no alignment check. retire_cnt wraps modulo 2^64.
- HALT:
  - halted=1; no requests; pc and inst hold.
  - start -> same actions as IDLE start.
- Steady state takes L+1 cycles per instruction (L = memory latency, L>=1).
- imem_rvalid outside FETCH is ignored and must not alter inst.
- Reset mid-fetch: immediate return to reset values. imem_req deasserts asynchronously; a late rvalid after reset is ignored.
- start outside IDLE/HALT is ignored.
- Outputs exec_en, rf_wr_gate, imem_req and halted decode directly from the registered state, with no combinational path from inputs.

Test Plan:
- Basic fetch, 1-cycle memory:
  - Stimulus: reset, start; rvalid one cycle after each req with rdata=32'h00500093; next_pc=pc+4.
  - Required: imem_addr sequence 8000_0000, 8000_0004, 8000_0008; exec_en every 2nd cycle; retire_cnt=3 after 3 instructions.
- Variable latency:
  - Stimulus: rvalid delayed 5 cycles.
  - Required: imem_req high 5 cycles; exec_en single pulse; inst=rdata; pc advances by 4 only after EXEC.
- Branch:
  - Stimulus: next_pc=32'h8000_0100 in EXEC.
  - Required: next imem_addr=8000_0100.
- ebreak:
  - Stimulus: inst_ebreak=1 in EXEC of the 4th instruction.
  - Required: halted=1 next cycle; retire_cnt=4; imem_req stays 0; start restarts at 8000_0000 with retire_cnt=0.
- Timeout (TIMEOUT=8):
  - Stimulus: no rvalid.
  - Required: fetch_err=1 and halted=1 after 8 wait cycles.
  - Stimulus: rvalid exactly on the 8th wait cycle.
  - Required: normal EXEC, fetch_err=0.
- Reset mid-fetch and stray rvalid:
  - Stimulus: assert rst during FETCH.
  - Required: imem_req=0 immediately; pc=8000_0000.
  - Stimulus: rvalid pulse while in IDLE.
  - Required: inst stays 32'h0000_0013.
